// File: rtl/reorder_buffer_if.sv
// Issue, CDB, operand-query and commit signals between the dispatcher side and the reorder buffer.
// The dispatcher/bench side uses the master modport and the reorder buffer uses the slave modport.
interface reorder_buffer_if #(
    parameter int ROB_WIDTH_BIT = 4
);
    logic                     inst_valid;
    logic [4:0]               inst_rd;
    logic                     inst_ready;
    logic [31:0]              inst_value;
    logic                     full;
    logic [ROB_WIDTH_BIT-1:0] alloc_id;

    logic                     rs_ready;
    logic [ROB_WIDTH_BIT-1:0] rs_rob_id;
    logic [31:0]              rs_value;
    logic                     lsb_ready;
    logic [ROB_WIDTH_BIT-1:0] lsb_rob_id;
    logic [31:0]              lsb_value;

    logic [ROB_WIDTH_BIT-1:0] q1_id;
    logic [ROB_WIDTH_BIT-1:0] q2_id;
    logic                     q1_ready;
    logic                     q2_ready;
    logic [31:0]              q1_value;
    logic [31:0]              q2_value;

    logic                     commit_valid;
    logic [ROB_WIDTH_BIT-1:0] commit_rob_id;
    logic [4:0]               commit_rd;
    logic [31:0]              commit_value;

    modport master (
        output inst_valid, inst_rd, inst_ready, inst_value,
        output rs_ready, rs_rob_id, rs_value, lsb_ready, lsb_rob_id, lsb_value,
        output q1_id, q2_id,
        input  full, alloc_id, q1_ready, q2_ready, q1_value, q2_value,
        input  commit_valid, commit_rob_id, commit_rd, commit_value
    );

    modport slave (
        input  inst_valid, inst_rd, inst_ready, inst_value,
        input  rs_ready, rs_rob_id, rs_value, lsb_ready, lsb_rob_id, lsb_value,
        input  q1_id, q2_id,
        output full, alloc_id, q1_ready, q2_ready, q1_value, q2_value,
        output commit_valid, commit_rob_id, commit_rd, commit_value
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at tail, captures rs/lsb results, retires the head in program order.
// Optional macro ROB_CDB_BYPASS_EN forwards same-cycle CDB broadcasts into the operand queries.
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

module reorder_buffer #(
    parameter int ROB_WIDTH_BIT = `ROB_WIDTH_BIT
) (
    input logic            clk_in,
    input logic            rst_n_in,
    input logic            rdy_in,
    input logic            clear_in,
    reorder_buffer_if.slave bus
);
    localparam int RobSize = 1 << ROB_WIDTH_BIT;

    typedef logic [ROB_WIDTH_BIT-1:0] robId_t;

    logic [RobSize-1:0] busy_q, busy_d;
    logic [RobSize-1:0] ready_q, ready_d;
    logic [4:0]         rd_q    [RobSize];
    logic [4:0]         rd_d    [RobSize];
    logic [31:0]        value_q [RobSize];
    logic [31:0]        value_d [RobSize];
    robId_t             head_q, head_d;
    robId_t             tail_q, tail_d;
    logic [ROB_WIDTH_BIT:0] count_q, count_d;

    logic        commitValid_q, commitValid_d;
    robId_t      commitRobId_q, commitRobId_d;
    logic [4:0]  commitRd_q, commitRd_d;
    logic [31:0] commitValue_q, commitValue_d;

    logic full;
    logic doIssue;
    logic doCommit;

    assign full     = (count_q == (ROB_WIDTH_BIT+1)'(RobSize));
    assign doIssue  = bus.inst_valid && !full;
    // Retirement looks only at registered state, so a result captured this edge retires one edge later.
    assign doCommit = busy_q[head_q] && ready_q[head_q];

    always_comb begin
        busy_d        = busy_q;
        ready_d       = ready_q;
        rd_d          = rd_q;
        value_d       = value_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        commitValid_d = 1'b0;
        commitRobId_d = commitRobId_q;
        commitRd_d    = commitRd_q;
        commitValue_d = commitValue_q;

        if (clear_in) begin
            busy_d        = '0;
            ready_d       = '0;
            rd_d          = '{default: '0};
            value_d       = '{default: '0};
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
            commitRobId_d = '0;
            commitRd_d    = '0;
            commitValue_d = '0;
        end else if (rdy_in) begin
            if (bus.rs_ready && busy_q[bus.rs_rob_id] && !ready_q[bus.rs_rob_id]) begin
                ready_d[bus.rs_rob_id] = 1'b1;
                value_d[bus.rs_rob_id] = bus.rs_value;
            end
            // Applied after the ALU bus so the load/store result wins a same-id collision.
            if (bus.lsb_ready && busy_q[bus.lsb_rob_id] && !ready_q[bus.lsb_rob_id]) begin
                ready_d[bus.lsb_rob_id] = 1'b1;
                value_d[bus.lsb_rob_id] = bus.lsb_value;
            end
            if (doIssue) begin
                busy_d[tail_q]  = 1'b1;
                ready_d[tail_q] = bus.inst_ready;
                rd_d[tail_q]    = bus.inst_rd;
                value_d[tail_q] = bus.inst_value;
                tail_d          = tail_q + 1'b1;
            end
            if (doCommit) begin
                commitValid_d  = 1'b1;
                commitRobId_d  = head_q;
                commitRd_d     = rd_q[head_q];
                commitValue_d  = value_q[head_q];
                busy_d[head_q] = 1'b0;
                head_d         = head_q + 1'b1;
            end
            count_d = count_q + (ROB_WIDTH_BIT+1)'(doIssue) - (ROB_WIDTH_BIT+1)'(doCommit);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q        <= '0;
            ready_q       <= '0;
            rd_q          <= '{default: '0};
            value_q       <= '{default: '0};
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            commitValid_q <= 1'b0;
            commitRobId_q <= '0;
            commitRd_q    <= '0;
            commitValue_q <= '0;
        end else begin
            busy_q        <= busy_d;
            ready_q       <= ready_d;
            rd_q          <= rd_d;
            value_q       <= value_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            commitValid_q <= commitValid_d;
            commitRobId_q <= commitRobId_d;
            commitRd_q    <= commitRd_d;
            commitValue_q <= commitValue_d;
        end
    end

    robId_t      qId    [2];
    logic        qReady [2];
    logic [31:0] qValue [2];

    assign qId[0] = bus.q1_id;
    assign qId[1] = bus.q2_id;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            qReady[i] = 1'b0;
            qValue[i] = '0;
            if (busy_q[qId[i]]) begin
                qReady[i] = ready_q[qId[i]];
                qValue[i] = value_q[qId[i]];
`ifdef ROB_CDB_BYPASS_EN
                if (!ready_q[qId[i]]) begin
                    if (bus.lsb_ready && bus.lsb_rob_id == qId[i]) begin
                        qReady[i] = 1'b1;
                        qValue[i] = bus.lsb_value;
                    end else if (bus.rs_ready && bus.rs_rob_id == qId[i]) begin
                        qReady[i] = 1'b1;
                        qValue[i] = bus.rs_value;
                    end
                end
`endif
            end
        end
    end

    assign bus.full          = full;
    assign bus.alloc_id      = tail_q;
    assign bus.q1_ready      = qReady[0];
    assign bus.q1_value      = qValue[0];
    assign bus.q2_ready      = qReady[1];
    assign bus.q2_value      = qValue[1];
    assign bus.commit_valid  = commitValid_q;
    assign bus.commit_rob_id = commitRobId_q;
    assign bus.commit_rd     = commitRd_q;
    assign bus.commit_value  = commitValue_q;
endmodule
